// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM responder: config-window offsets,
// read-source select encoding and the byte-lane merge helper.
package data_sram_resp_pkg;

  localparam logic [15:0] CONF_BASE_DEFAULT = 16'hbfaf;

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;
  localparam logic [15:0] OFF_TIMER  = 16'he000;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH,
    SEL_TIMER,
    SEL_NONE
  } sel_e;

  // Replace only the bytes whose write-enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_resp_bram_be.sv
// Single-port word RAM with four byte-enable write lanes and a registered,
// read-first output port.
module bram_be #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Storage is never reset; only the output register is cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-writable RAM plus a config-register window
// (LED, number display, switches, free-running timer), one-cycle read latency.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  logic        conf_hit;
  logic [15:0] offset;
  logic        wr;
  sel_e        sel;
  sel_e        sel_q;
  logic [31:0] conf_rd;
  logic [31:0] conf_rd_q;
  logic [31:0] ram_rdata;
  logic [31:0] timer;
  logic [15:0] led_merged;
  logic [31:0] num_merged;
  logic [31:0] timer_merged;

  assign conf_hit = (data_sram_addr[31:16] == CONF_BASE);
  assign offset   = data_sram_addr[15:0];
  assign wr       = data_sram_en && (data_sram_wen != 4'b0000);

  always_comb begin
    sel = SEL_NONE;
    if (!conf_hit) begin
      sel = SEL_RAM;
    end else begin
      case (offset)
        OFF_LED:    sel = SEL_LED;
        OFF_NUM:    sel = SEL_NUM;
        OFF_SWITCH: sel = SEL_SWITCH;
        OFF_TIMER:  sel = SEL_TIMER;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    conf_rd = '0;
    case (sel)
      SEL_LED:    conf_rd = {16'h0000, led};
      SEL_NUM:    conf_rd = num_data;
      SEL_SWITCH: conf_rd = {24'h000000, switch};
      SEL_TIMER:  conf_rd = timer;
      default:    conf_rd = '0;
    endcase
  end

  assign led_merged   = 16'(byte_merge({16'h0000, led}, data_sram_wdata, data_sram_wen));
  assign num_merged   = byte_merge(num_data, data_sram_wdata, data_sram_wen);
  assign timer_merged = byte_merge(timer, data_sram_wdata, data_sram_wen);

  bram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en     (data_sram_en && (sel == SEL_RAM)),
    .wen    (data_sram_wen),
    .addr   (data_sram_addr[ADDR_W+1:2]),
    .wdata  (data_sram_wdata),
    .rdata  (ram_rdata)
  );

  // A timer write replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      num_data <= '0;
      timer    <= '0;
    end else begin
      if (wr && sel == SEL_LED) led <= led_merged;
      if (wr && sel == SEL_NUM) num_data <= num_merged;
      if (wr && sel == SEL_TIMER) timer <= timer_merged;
      else timer <= timer + 32'd1;
    end
  end

  // Select is registered alongside the config value to line up with the RAM output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q     <= SEL_NONE;
      conf_rd_q <= '0;
    end else if (data_sram_en) begin
      sel_q     <= sel;
      conf_rd_q <= conf_rd;
    end
  end

  assign data_sram_rdata = (sel_q == SEL_RAM) ? ram_rdata : conf_rd_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: directed plan sequences then random
// traffic checked against a behavioural word/register model.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num_data        (num_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m[int];
  logic [15:0] led_m;
  logic [31:0] num_m;
  logic [31:0] timer_m;
  logic        resp_due;
  logic [13:0] pool[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                       input logic [3:0] wen);
    logic [31:0] mask;
    mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // One bus cycle: drive, predict response from the model, advance the model past the edge.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [7:0] sw);
    logic [31:0] expv;
    logic [31:0] tmp;
    logic [15:0] nxt_led;
    logic [31:0] nxt_num;
    logic [31:0] nxt_timer;
    int          idx;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    switch          = sw;
    nxt_led   = led_m;
    nxt_num   = num_m;
    nxt_timer = timer_m + 32'd1;
    expv      = '0;
    if (en) begin
      if (addr[31:16] == 16'hbfaf) begin
        case (addr[15:0])
          16'hf000: begin
            expv = {16'h0000, led_m};
            tmp = merge({16'h0000, led_m}, wdata, wen);
            nxt_led = tmp[15:0];
          end
          16'hf010: begin
            expv = num_m;
            nxt_num = merge(num_m, wdata, wen);
          end
          16'hf020: expv = {24'h000000, sw};
          16'he000: begin
            expv = timer_m;
            if (wen != 4'b0000) nxt_timer = merge(timer_m, wdata, wen);
          end
          default: expv = '0;
        endcase
      end else begin
        idx = int'(addr[15:2]);
        expv = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        mem_m[idx] = merge(expv, wdata, wen);
      end
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    led_m   = nxt_led;
    num_m   = nxt_num;
    timer_m = nxt_timer;
    checkOutput("led", {16'h0000, led}, {16'h0000, led_m});
    checkOutput("num_data", num_data, num_m);
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) resp_due <= 1'b0;
    else resp_due <= data_sram_en;
  end

  always @(negedge clk) begin
    if (resp_due) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rdata: got %h with no expected response queued", data_sram_rdata);
      end else begin
        checkOutput("rdata", data_sram_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] upper;
    logic [15:0] off;
    logic [31:0] other_offs[4];
    int          r;
    other_offs = '{32'h0000f004, 32'h00000000, 32'h0000e004, 32'h0000f030};

    resetn = 1'b1;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = '0;
    data_sram_wdata = '0;
    switch = 8'h00;
    #2 resetn = 1'b0;
    #1;
    checkOutput("reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("reset_led", {16'h0000, led}, 32'h0);
    checkOutput("reset_num", num_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    led_m = '0;
    num_m = '0;
    timer_m = 32'd1;

    applyStimulus(1'b1, 4'hf, 32'h00000100, 32'h12345678, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'h00000100, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'b0101, 32'h00000100, 32'haabbccdd, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'h00000100, 32'h0, 8'h00);
    checkOutput("model_lane_merge", mem_m[32'h40], 32'h12bb56dd);
    applyStimulus(1'b1, 4'hf, 32'h00000100, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'h00000100, 32'h0, 8'h00);

    applyStimulus(1'b1, 4'hf, 32'hbfaff000, 32'h0000beef, 8'h00);
    checkOutput("led_beef", {16'h0000, led}, 32'h0000beef);
    applyStimulus(1'b1, 4'h0, 32'hbfaff000, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'hbfaff020, 32'h0, 8'h5a);
    applyStimulus(1'b1, 4'hf, 32'hbfaff020, 32'hffffffff, 8'h5a);
    applyStimulus(1'b1, 4'h0, 32'hbfaff020, 32'h0, 8'h5a);

    applyStimulus(1'b1, 4'hf, 32'hbfafe000, 32'hfffffffe, 8'h00);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'h00);

    applyStimulus(1'b1, 4'hf, 32'h00000200, 32'hcafef00d, 8'h00);
    applyStimulus(1'b1, 4'hf, 32'hbfaff010, 32'h87654321, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'hbfaff010, 32'h0, 8'h00);
    // Reset lands while that NUM read is still being presented.
    data_sram_en = 1'b0;
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midreset_rdata", data_sram_rdata, 32'h0);
    checkOutput("midreset_led", {16'h0000, led}, 32'h0);
    checkOutput("midreset_num", num_data, 32'h0);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    led_m = '0;
    num_m = '0;
    timer_m = 32'd1;
    applyStimulus(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'h00);
    applyStimulus(1'b1, 4'h0, 32'h00000200, 32'h0, 8'h00);

    for (int k = 0; k < 8; k++) begin
      pool[k] = 14'($urandom);
      applyStimulus(1'b1, 4'hf, {16'h0000, pool[k], 2'b00}, $urandom, 8'h00);
    end

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      upper = 16'($urandom);
      if (upper == 16'hbfaf) upper = 16'h0000;
      case (r)
        0, 1: applyStimulus(1'b0, 4'($urandom), $urandom, $urandom, 8'($urandom));
        2, 3, 4, 5:
          applyStimulus(1'b1, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                        {upper, pool[$urandom_range(0, 7)], 2'($urandom)}, $urandom, 8'($urandom));
        6, 7, 8: begin
          case ($urandom_range(0, 4))
            0: off = 16'hf000;
            1: off = 16'hf010;
            2: off = 16'hf020;
            3: off = 16'he000;
            default: off = other_offs[$urandom_range(0, 3)][15:0];
          endcase
          applyStimulus(1'b1, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                        {16'hbfaf, off}, $urandom, 8'($urandom));
        end
        default: applyStimulus(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'($urandom));
      endcase
    end

    repeat (3) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d responses never presented, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
